// File: rtl/cella_pkg.sv
// Shared encodings and sizing for the CELLA array command sequencer.
package cella_pkg;

  localparam int NUM_ROWS = 4;
  localparam int KEY_W    = 4;
  localparam int ROW_W    = 2;
  localparam int TMR_W    = 8;

  localparam logic [1:0] OP_ROW_RD = 2'b00;
  localparam logic [1:0] OP_ROW_WR = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
  localparam logic [1:0] OP_MAC    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WL,
    ST_SENSE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/cella_phase_timer.sv
// Phase down-counter: start loads len-1, done is high on the final cycle of the phase.
module cella_phase_timer
  import cella_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [TMR_W-1:0] len,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= len - TMR_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/cella_array_ctrl.sv
// Command sequencer feeding row_decoder: programs decoder inputs, runs
// precharge/wordline/sense phases and returns one result per command.
module cella_array_ctrl
  import cella_pkg::*;
#(
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 1,
  parameter int SENSE_W = 4,
  parameter int ACC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [1:0]         cmd_addr,
  input  logic [KEY_W-1:0]   cmd_key,
  input  logic [SENSE_W-1:0] sense_in,
  output logic               MAC_en,
  output logic               read_bar,
  output logic               addr0,
  output logic               addr1,
  output logic               data0,
  output logic               data1,
  output logic               data2,
  output logic               data3,
  output logic               precharge_en,
  output logic               wl_gate,
  output logic               sense_en,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ACC_W-1:0]   rsp_data,
  output logic               busy
);

  function automatic logic [ACC_W-1:0] popcount(input logic [SENSE_W-1:0] v);
    logic [ACC_W-1:0] n;
    n = '0;
    for (int i = 0; i < SENSE_W; i++) n = n + ACC_W'(v[i]);
    return n;
  endfunction

  state_t             state;
  logic [1:0]         op_q;
  logic [KEY_W-1:0]   key_q;
  logic [ROW_W-1:0]   row;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic               last_row;
  logic               tmr_start;
  logic [TMR_W-1:0]   tmr_len;
  logic               tmr_done;

  assign acc_sum  = acc + (key_q[row] ? popcount(sense_in) : '0);
  assign last_row = (row == ROW_W'(NUM_ROWS - 1));

  // Timer reloads on every entry to PRE (including each sweep row) and WL
  always_comb begin
    tmr_start = 1'b0;
    tmr_len   = TMR_W'(PRE_CYC);
    case (state)
      ST_IDLE:  tmr_start = cmd_valid;
      ST_PRE:   begin
        tmr_start = tmr_done;
        tmr_len   = TMR_W'(WL_CYC);
      end
      ST_SENSE: tmr_start = (op_q == OP_MAC) && !last_row;
      default:  tmr_start = 1'b0;
    endcase
  end

  cella_phase_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tmr_start),
    .len   (tmr_len),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      op_q         <= OP_ROW_RD;
      key_q        <= '0;
      row          <= '0;
      acc          <= '0;
      MAC_en       <= 1'b1;
      read_bar     <= 1'b0;
      {addr1, addr0}               <= 2'b00;
      {data3, data2, data1, data0} <= 4'b0000;
      precharge_en <= 1'b0;
      wl_gate      <= 1'b0;
      sense_en     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state        <= ST_PRE;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            precharge_en <= 1'b1;
            op_q         <= cmd_op;
            key_q        <= cmd_key;
            row          <= '0;
            acc          <= '0;
            MAC_en       <= (cmd_op != OP_SEARCH);
            read_bar     <= (cmd_op == OP_ROW_WR);
            {addr1, addr0} <= (cmd_op == OP_ROW_RD || cmd_op == OP_ROW_WR) ? cmd_addr : 2'b00;
            {data3, data2, data1, data0} <= (cmd_op == OP_SEARCH) ? cmd_key : 4'b0000;
          end
        end
        ST_PRE: begin
          if (tmr_done) begin
            state        <= ST_WL;
            precharge_en <= 1'b0;
            wl_gate      <= 1'b1;
          end
        end
        ST_WL: begin
          if (tmr_done) begin
            state    <= ST_SENSE;
            sense_en <= 1'b1;
          end
        end
        ST_SENSE: begin
          wl_gate  <= 1'b0;
          sense_en <= 1'b0;
          if (op_q == OP_MAC) begin
            acc <= acc_sum;
            if (last_row) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= acc_sum;
            end else begin
              state          <= ST_PRE;
              precharge_en   <= 1'b1;
              row            <= row + ROW_W'(1);
              {addr1, addr0} <= row + ROW_W'(1);
            end
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= (op_q == OP_ROW_WR) ? '0 : ACC_W'(sense_in);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            MAC_en    <= 1'b1;
            read_bar  <= 1'b0;
            {addr1, addr0}               <= 2'b00;
            {data3, data2, data1, data0} <= 4'b0000;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
